// File: rtl/key_debounce_pkg.sv
// +--------------------------------------------------------------------------+
// | key_debounce_pkg : shared state encoding and 50 MHz timing defaults      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 32'd50000;
  localparam int unsigned DEF_REPEAT_DELAY  = 32'd25000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 32'd5000000;

endpackage

`default_nettype wire

// File: rtl/key_debounce_pulse_repeat_timer.sv
// +--------------------------------------------------------------------------+
// | key_debounce_pulse_repeat_timer : auto-repeat counter and strobe source  |
// | Used only when KEY_DEBOUNCE_REPEAT_EN is defined. Revision 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module key_debounce_pulse_repeat_timer #(
  parameter int unsigned REPEAT_DELAY  = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD = 32'd5000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic run_i,
  input  logic freeze_i,
  output logic fire_o
);

  localparam int unsigned MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int          CW      = $clog2(MAX_CNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rearm_q, rearm_d;
  logic [CW-1:0] target;

  // First strobe waits the long delay; later strobes use the shorter period.
  assign target = rearm_q ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1);

  always_comb begin
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    fire_o  = 1'b0;
    if (run_i) begin
      if (cnt_q == target) begin
        fire_o  = 1'b1;
        cnt_d   = '0;
        rearm_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!freeze_i) begin
      cnt_d   = '0;
      rearm_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      rearm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_debounce_pulse.sv
// +--------------------------------------------------------------------------+
// | key_debounce_pulse : debounced level plus one-cycle press/release strobes |
// | Optional auto-repeat: define KEY_DEBOUNCE_REPEAT_EN. Revision 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module key_debounce_pulse
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d_sync,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int            CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_fire;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  key_debounce_pulse_repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .run_i    (state_q == HELD),
    .freeze_i (state_q == WAIT_LOW),
    .fire_o   (repeat_fire)
  );
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign repeat_fire       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!d_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        press_d = repeat_fire;
        if (!d_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (d_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
// +--------------------------------------------------------------------------+
// | tb_key_debounce_pulse : directed self-checking bench, STABLE_CYCLES=4     |
// | Repeat expectations follow KEY_DEBOUNCE_REPEAT_EN. Revision 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_key_debounce_pulse;

  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned REPEAT_DELAY  = 10;
  localparam int unsigned REPEAT_PERIOD = 3;
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic Clk, Reset, d_sync;
  logic level, press_pulse, release_pulse;
  logic [2:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  int n_press  = 0;

  key_debounce_pulse #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .d_sync        (d_sync),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign obs = {level, press_pulse, release_pulse};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Each step samples {level, press, release} 1 ns after the edge it follows.
  task automatic release_seq(input string tag);
    d_sync = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check(tag, 32'(obs), (i == 4) ? 32'b001 : 32'b100);
    end
    step();
    check({tag, "_after"}, 32'(obs), 32'b000);
  endtask

  initial begin
    logic [7:0] bounce_pat;
    logic       exp_p;
    int         k;

    Reset  = 1'b1;
    d_sync = 1'b0;
    step();
    step();
    check("reset_state", 32'(obs), 32'b000);
    Reset = 1'b0;

    d_sync = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("clean_press", 32'(obs), (i < 4) ? 32'b000 : (i == 4) ? 32'b110 : 32'b100);
    end

    d_sync = 1'b0; step(); check("glitch0a", 32'(obs), 32'b100);
    d_sync = 1'b0; step(); check("glitch0b", 32'(obs), 32'b100);
    d_sync = 1'b1; step(); check("glitch1",  32'(obs), 32'b100);
    step();               check("glitch_hold", 32'(obs), 32'b100);

    release_seq("release1");

    bounce_pat = 8'b1111_0111;
    for (int i = 0; i < 8; i++) begin
      d_sync = bounce_pat[i];
      step();
      check("bounce", 32'(obs), (i == 7) ? 32'b110 : 32'b000);
    end

    // Reset lands while press_pulse is high; d_sync stays high throughout.
    Reset = 1'b1;
    #1;
    check("rst_mid_pulse", 32'(obs), 32'b000);
    step();
    check("rst_held", 32'(obs), 32'b000);
    Reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("post_rst_count", 32'(obs), 32'b000);
    end
    Reset = 1'b1;
    #1;
    check("rst_mid_count", 32'(obs), 32'b000);
    step();
    Reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("requalify", 32'(obs), (i == 4) ? 32'b110 : 32'b000);
    end
    step();
    check("requalify_hold", 32'(obs), 32'b100);

    release_seq("release2");

    d_sync = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      step();
      k     = i - 4;
      exp_p = (k == 0) || (REPEAT_ON && k >= 10 && ((k - 10) % 3) == 0);
      check("repeat", 32'(obs), {29'd0, (i >= 4), exp_p, 1'b0});
      if (press_pulse) n_press++;
    end
    check("repeat_count", 32'(n_press), REPEAT_ON ? 32'd8 : 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
